// File: rtl/tmr_sram_2kbit.sv
// 256x8 single-port SRAM hardened by triple modular redundancy.
// Reads return the bitwise 2-of-3 vote; disagreeing copies are flagged and optionally scrubbed.

module tmr_sram_2kbit_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_rd
);

    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= data_in;
        end
    end

    // Asynchronous read; the top registers the voted word.
    assign data_rd = mem[addr];

endmodule

module tmr_sram_2kbit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SCRUB  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              err
);

    localparam logic SCRUB_EN = (SCRUB != 0);

    logic [DATA_W-1:0] rd_1, rd_2, rd_3;
    logic [DATA_W-1:0] voted;
    logic [DATA_W-1:0] wr_data;
    logic              mismatch;
    logic              rd_access;
    logic              wr_access;

    function automatic logic [DATA_W-1:0] vote(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign voted     = vote(rd_1, rd_2, rd_3);
    assign mismatch  = (rd_1 != rd_2) || (rd_1 != rd_3);
    assign rd_access = rst && enable && !we;
    // A scrubbing read reuses the write port to restore all copies to the voted word.
    assign wr_access = rst && enable && (we || (SCRUB_EN && mismatch));
    assign wr_data   = we ? data_in : voted;

    tmr_sram_2kbit_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memory_1 (
        .clk(clk), .wr(wr_access), .addr(addr), .data_in(wr_data), .data_rd(rd_1)
    );

    tmr_sram_2kbit_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memory_2 (
        .clk(clk), .wr(wr_access), .addr(addr), .data_in(wr_data), .data_rd(rd_2)
    );

    tmr_sram_2kbit_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memory_3 (
        .clk(clk), .wr(wr_access), .addr(addr), .data_in(wr_data), .data_rd(rd_3)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            err      <= 1'b0;
        end else if (rd_access) begin
            data_out <= voted;
            err      <= mismatch;
        end
    end

endmodule

// File: tb/tb_tmr_sram_2kbit.sv
// Scoreboard bench for tmr_sram_2kbit: a three-copy memory model predicts each cycle's outputs.

module tb_tmr_sram_2kbit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int SCRUB  = 1;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       err;

    logic [7:0] m1 [256];
    logic [7:0] m2 [256];
    logic [7:0] m3 [256];
    logic [8:0] exp_q [$];
    logic [8:0] last;
    int         n_chk;
    int         n_err;

    tmr_sram_2kbit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCRUB(SCRUB)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .we(we),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // One bus cycle: drive at negedge, predict, then compare just after the rising edge.
    task automatic cyc(input string tag, input logic en, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
        logic [7:0] v;
        logic       e;
        logic [8:0] exp_v;
        @(negedge clk);
        enable  = en;
        we      = w;
        addr    = a;
        data_in = d;
        if (en && !w) begin
            v = maj(m1[a], m2[a], m3[a]);
            e = (m1[a] != m2[a]) || (m1[a] != m3[a]);
            if (SCRUB != 0 && e) begin
                m1[a] = v;
                m2[a] = v;
                m3[a] = v;
            end
            last = {e, v};
        end else if (en) begin
            m1[a] = d;
            m2[a] = d;
            m3[a] = d;
        end
        exp_q.push_back(last);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check({tag, "_data"}, {24'h0, data_out}, {24'h0, exp_v[7:0]});
        check({tag, "_err"}, {31'h0, err}, {31'h0, exp_v[8]});
    endtask

    task automatic inject(input int copy, input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        enable = 1'b0;
        case (copy)
            1: begin dut.memory_1.mem[a] <= v; m1[a] = v; end
            2: begin dut.memory_2.mem[a] <= v; m2[a] = v; end
            default: begin dut.memory_3.mem[a] <= v; m3[a] = v; end
        endcase
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        last    = '0;
        enable  = 1'b0;
        we      = 1'b0;
        addr    = '0;
        data_in = '0;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #20;
        check("reset_data", {24'h0, data_out}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        cyc("wr10", 1'b1, 1'b1, 8'd10, 8'h2C);
        cyc("wr20", 1'b1, 1'b1, 8'd20, 8'h3C);
        cyc("wr30", 1'b1, 1'b1, 8'd30, 8'hA5);
        cyc("rd10", 1'b1, 1'b0, 8'd10, 8'h00);
        cyc("rd20", 1'b1, 1'b0, 8'd20, 8'h00);
        cyc("rd30", 1'b1, 1'b0, 8'd30, 8'h00);

        inject(1, 8'd10, 8'h00);
        cyc("rd10_single_fault", 1'b1, 1'b0, 8'd10, 8'h00);
        cyc("rd10_scrubbed", 1'b1, 1'b0, 8'd10, 8'h00);

        inject(1, 8'd20, 8'h0F);
        inject(2, 8'd20, 8'hFF);
        cyc("rd20_double_fault", 1'b1, 1'b0, 8'd20, 8'h00);

        cyc("rd30_clean", 1'b1, 1'b0, 8'd30, 8'h00);
        inject(3, 8'd30, 8'h00);
        cyc("idle_a", 1'b0, 1'b0, 8'd30, 8'h55);
        cyc("idle_b", 1'b0, 1'b1, 8'd31, 8'hAA);
        cyc("rd30_fault", 1'b1, 1'b0, 8'd30, 8'h00);

        cyc("wr0", 1'b1, 1'b1, 8'd0, 8'hFF);
        cyc("wr255", 1'b1, 1'b1, 8'd255, 8'h01);
        cyc("rd0", 1'b1, 1'b0, 8'd0, 8'h00);
        cyc("rd255", 1'b1, 1'b0, 8'd255, 8'h00);
        cyc("wr_after_rd", 1'b1, 1'b1, 8'd40, 8'h77);

        for (int i = 0; i < 8; i++) begin
            cyc("rnd_wr", 1'b1, 1'b1, 8'(100 + i), 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 8; i++) begin
            cyc("rnd_rd", 1'b1, 1'b0, 8'(100 + i), 8'h00);
        end

        // Asynchronous reset asserted between clock edges.
        @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_data", {24'h0, data_out}, 32'h0);
        check("midrst_err", {31'h0, err}, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_hold_data", {24'h0, data_out}, 32'h0);
        @(negedge clk);
        rst  = 1'b1;
        last = '0;
        #1;
        check("release_data", {24'h0, data_out}, 32'h0);
        check("release_err", {31'h0, err}, 32'h0);

        cyc("post_rd10", 1'b1, 1'b0, 8'd10, 8'h00);
        cyc("post_rd20", 1'b1, 1'b0, 8'd20, 8'h00);
        cyc("post_rd30", 1'b1, 1'b0, 8'd30, 8'h00);
        cyc("post_rd0", 1'b1, 1'b0, 8'd0, 8'h00);
        cyc("post_rd255", 1'b1, 1'b0, 8'd255, 8'h00);
        cyc("post_rd40", 1'b1, 1'b0, 8'd40, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
